multicycle_ctrl_fsm: RTL and testbench

Multi-cycle control sequencer for the 8-bit, 16-bit-instruction CPU datapath. It replaces single-cycle combinational control with a registered state machine: FETCH, DECODE, EXEC, MEM and WB. It drives the datapath control strobes, the fetch-unit PC advance and data-memory handshaking. It also counts retired instructions and stops on HALT or a memory timeout.

---
 rtl/multicycle_ctrl_fsm_pkg.sv | 54 +++++
 rtl/multicycle_ctrl_fsm_if.sv | 33 +++
 rtl/multicycle_ctrl_fsm_dec.sv | 27 ++
 rtl/multicycle_ctrl_fsm.sv | 141 ++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared constants and types for the multi-cycle control sequencer:
// opcode map, instruction classes, state encoding and ImmSrc codes.
package multicycle_ctrl_fsm_pkg;

  localparam int TMO_W = 8;

  localparam logic [3:0] OP_IALU0 = 4'h6;
  localparam logic [3:0] OP_IALU1 = 4'h7;
  localparam logic [3:0] OP_STORE = 4'h8;
  localparam logic [3:0] OP_LOAD  = 4'h9;
  localparam logic [3:0] OP_LI    = 4'hA;
  localparam logic [3:0] OP_BR0   = 4'hB;
  localparam logic [3:0] OP_BR1   = 4'hC;
  localparam logic [3:0] OP_JUMP  = 4'hD;
  localparam logic [3:0] OP_NOP   = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    CLS_RALU, CLS_IALU, CLS_STORE, CLS_LOAD, CLS_LI,
    CLS_BRANCH, CLS_JUMP, CLS_NOP, CLS_HALT
  } op_class_e;

  function automatic op_class_e classify(input logic [3:0] op);
    op_class_e c;
    case (op)
      OP_IALU0, OP_IALU1: c = CLS_IALU;
      OP_STORE:           c = CLS_STORE;
      OP_LOAD:            c = CLS_LOAD;
      OP_LI:              c = CLS_LI;
      OP_BR0, OP_BR1:     c = CLS_BRANCH;
      OP_JUMP:            c = CLS_JUMP;
      OP_NOP:             c = CLS_NOP;
      OP_HALT:            c = CLS_HALT;
      default:            c = CLS_RALU;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Bus between the control sequencer and the datapath / fetch / data memory.
interface multicycle_ctrl_fsm_if #(parameter int RETIRE_W = 16);
  logic                run;
  logic [3:0]          opcode;
  logic                instr_valid;
  logic                mem_ready;
  logic                ResultSrc;
  logic                MemRead;
  logic                MemWrite;
  logic                ALUSrc;
  logic [1:0]          ImmSrc;
  logic                RegWrite;
  logic                Branch;
  logic                Jump;
  logic                pc_en;
  logic                ir_load;
  logic                halted;
  logic                mem_err;
  logic [RETIRE_W-1:0] retired;
  logic [2:0]          state_dbg;

  modport master (
    output run, opcode, instr_valid, mem_ready,
    input  ResultSrc, MemRead, MemWrite, ALUSrc, ImmSrc, RegWrite, Branch, Jump,
           pc_en, ir_load, halted, mem_err, retired, state_dbg
  );

  modport slave (
    input  run, opcode, instr_valid, mem_ready,
    output ResultSrc, MemRead, MemWrite, ALUSrc, ImmSrc, RegWrite, Branch, Jump,
           pc_en, ir_load, halted, mem_err, retired, state_dbg
  );
endinterface

// File: rtl/multicycle_ctrl_fsm_dec.sv
// Opcode class decoder: maps an opcode to its class and the static
// ALU operand-B / immediate-format selects for that class.
module opcode_class_decoder
  import multicycle_ctrl_fsm_pkg::*;
(
  input  logic [3:0] op_i,
  output op_class_e  cls_o,
  output logic       alu_src_o,
  output logic [1:0] imm_src_o
);

  always_comb begin
    cls_o     = classify(op_i);
    alu_src_o = 1'b0;
    imm_src_o = IMM_I;
    case (cls_o)
      CLS_IALU:   begin alu_src_o = 1'b1; imm_src_o = IMM_I; end
      CLS_LI:     begin alu_src_o = 1'b1; imm_src_o = IMM_J; end
      CLS_LOAD:   begin alu_src_o = 1'b1; imm_src_o = IMM_I; end
      CLS_STORE:  begin alu_src_o = 1'b1; imm_src_o = IMM_S; end
      CLS_BRANCH: imm_src_o = IMM_B;
      CLS_JUMP:   imm_src_o = IMM_J;
      default:    ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB state machine with
// data-memory timeout, sticky halt/fault flags and a saturating retire counter.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int RETIRE_W    = 16
)(
  input  logic                 clk,
  input  logic                 reset,
  multicycle_ctrl_fsm_if.slave bus
);

  state_e              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                mem_err_q, mem_err_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;

  logic [3:0] dec_op;
  op_class_e  cls;
  logic       alu_src;
  logic [1:0] imm_src;
  logic       tmo_hit;
  logic       retire;
  state_e     done_st;

  // The live opcode is only looked at while decoding; afterwards the latched copy rules.
  assign dec_op = (state_q == ST_DECODE) ? bus.opcode : op_q;

  opcode_class_decoder u_dec (
    .op_i      (dec_op),
    .cls_o     (cls),
    .alu_src_o (alu_src),
    .imm_src_o (imm_src)
  );

  assign done_st = bus.run ? ST_FETCH : ST_IDLE;
  assign tmo_hit = (state_q == ST_MEM) && !bus.mem_ready &&
                   (tmo_q == TMO_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (bus.run) state_d = ST_FETCH;
      ST_FETCH:  if (bus.instr_valid) state_d = ST_DECODE;
      ST_DECODE: begin
        if (cls == CLS_NOP)       state_d = done_st;
        else if (cls == CLS_HALT) state_d = ST_HALT;
        else                      state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (cls == CLS_BRANCH || cls == CLS_JUMP)    state_d = done_st;
        else if (cls == CLS_LOAD || cls == CLS_STORE) state_d = ST_MEM;
        else                                          state_d = ST_WB;
      end
      ST_MEM: begin
        if (bus.mem_ready) state_d = (cls == CLS_LOAD) ? ST_WB : done_st;
        else if (tmo_hit)  state_d = ST_HALT;
      end
      ST_WB:   state_d = done_st;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.ResultSrc = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.ALUSrc    = 1'b0;
    bus.ImmSrc    = IMM_I;
    bus.RegWrite  = 1'b0;
    bus.Branch    = 1'b0;
    bus.Jump      = 1'b0;
    bus.pc_en     = 1'b0;
    bus.ir_load   = 1'b0;
    bus.halted    = 1'b0;
    unique case (state_q)
      ST_FETCH:  bus.ir_load = bus.instr_valid;
      ST_DECODE: bus.pc_en = (cls == CLS_NOP);
      ST_EXEC: begin
        bus.ALUSrc = alu_src;
        bus.ImmSrc = imm_src;
        bus.Branch = (cls == CLS_BRANCH);
        bus.Jump   = (cls == CLS_JUMP);
        bus.pc_en  = (cls == CLS_BRANCH) || (cls == CLS_JUMP);
      end
      ST_MEM: begin
        bus.ALUSrc   = alu_src;
        bus.ImmSrc   = imm_src;
        bus.MemRead  = (cls == CLS_LOAD);
        bus.MemWrite = (cls == CLS_STORE);
        bus.pc_en    = (cls == CLS_STORE) && bus.mem_ready;
      end
      ST_WB: begin
        bus.ALUSrc    = alu_src;
        bus.ImmSrc    = imm_src;
        bus.RegWrite  = 1'b1;
        bus.pc_en     = 1'b1;
        bus.ResultSrc = (cls == CLS_LOAD);
      end
      ST_HALT: bus.halted = 1'b1;
      default: ;
    endcase
  end

  // Every retire except HALT coincides with a PC advance.
  assign retire = bus.pc_en || ((state_q == ST_DECODE) && (cls == CLS_HALT));

  always_comb begin
    op_d      = (state_q == ST_DECODE) ? bus.opcode : op_q;
    tmo_d     = ((state_q == ST_MEM) && !bus.mem_ready) ? tmo_q + TMO_W'(1) : '0;
    mem_err_d = mem_err_q || tmo_hit;
    retired_d = (retire && (retired_q != '1)) ? retired_q + RETIRE_W'(1) : retired_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= '0;
      tmo_q     <= '0;
      mem_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      op_q      <= op_d;
      tmo_q     <= tmo_d;
      mem_err_q <= mem_err_d;
      retired_q <= retired_d;
    end
  end

  assign bus.mem_err   = mem_err_q;
  assign bus.retired   = retired_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: expected retire records are queued
// per instruction and checked when the DUT advances the PC.
module tb_multicycle_ctrl_fsm;

  localparam int RW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if #(.RETIRE_W(RW)) bus ();

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(15), .RETIRE_W(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] op;
    int         lat;
    logic [6:0] ctrl;
    int         mem;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_retired = 0;
  int   mem_delay_cfg = 0;
  int   wait_cnt = 0;
  int   cyc = 0;
  int   mem_cnt = 0;
  int   stray = 0;

  logic [14:0] outs;
  assign outs = {bus.ResultSrc, bus.MemRead, bus.MemWrite, bus.ALUSrc, bus.ImmSrc,
                 bus.RegWrite, bus.Branch, bus.Jump, bus.pc_en, bus.ir_load,
                 bus.halted, bus.mem_err, bus.state_dbg};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Data memory model: answers after mem_delay_cfg wait cycles.
  always @(posedge clk) begin
    #1;
    if (reset && (bus.MemRead || bus.MemWrite)) begin
      bus.mem_ready = (wait_cnt >= mem_delay_cfg);
      wait_cnt++;
    end else begin
      bus.mem_ready = 1'b0;
      wait_cnt = 0;
    end
  end

  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      cyc = 0; mem_cnt = 0; stray = 0;
    end else begin
      if (bus.ir_load) begin
        cyc = 1; mem_cnt = 0; stray = 0;
      end else begin
        cyc++;
      end
      if (bus.MemRead || bus.MemWrite) mem_cnt++;
      if ((bus.RegWrite || bus.Branch || bus.Jump || bus.ResultSrc) && !bus.pc_en) stray++;
      if (bus.pc_en) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_retire", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("latency", cyc, e.lat);
          check_eq("ctrl", {25'd0, bus.ResultSrc, bus.RegWrite, bus.Branch, bus.Jump,
                            bus.ALUSrc, bus.ImmSrc}, {25'd0, e.ctrl});
          check_eq("mem_strobe_cycles", mem_cnt, e.mem);
          check_eq("stray_strobes", stray, 0);
          $display("retire op=%h lat=%0d ctrl=%b mem=%0d", e.op, cyc, e.ctrl, mem_cnt);
        end
      end
    end
  end

  task automatic wait_ir_load();
    logic seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.ir_load) begin seen = 1'b1; break; end
    end
    check_eq("ir_load_seen", seen, 1'b1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (sb_q.size() == 0) break;
    end
    check_eq("sb_drain", sb_q.size(), 0);
  endtask

  task automatic wait_halted();
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (bus.halted) break;
    end
  endtask

  task automatic run_instr(input logic [3:0] op, input int delay, input int lat,
                           input logic [6:0] ctrl, input int mem, input bit drop_run);
    exp_t e;
    e.op = op; e.lat = lat; e.ctrl = ctrl; e.mem = mem;
    mem_delay_cfg = delay;
    sb_q.push_back(e);
    bus.opcode = op;
    bus.instr_valid = 1'b1;
    wait_ir_load();
    @(negedge clk);
    bus.instr_valid = 1'b0;
    if (drop_run) bus.run = 1'b0;
    @(posedge clk); #1;
    bus.opcode = 4'($urandom_range(0, 15));
    wait_drain();
    exp_retired++;
    check_eq("retired", bus.retired, exp_retired);
  endtask

  task automatic start_stuck_store();
    mem_delay_cfg = 1000;
    bus.opcode = 4'h8;
    bus.instr_valid = 1'b1;
    wait_ir_load();
    @(negedge clk);
    bus.instr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset = 1'b0;
    bus.run = 1'b0;
    bus.opcode = 4'h0;
    bus.instr_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    check_eq("reset_outputs", outs, 15'd0);
    check_eq("reset_retired", bus.retired, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_without_run", bus.state_dbg, 3'd0);
    bus.run = 1'b1;

    run_instr(4'h0, 0, 4, 7'b0100000, 0, 1'b0);
    run_instr(4'h6, 0, 4, 7'b0100100, 0, 1'b0);
    run_instr(4'hA, 0, 4, 7'b0100111, 0, 1'b0);
    run_instr(4'h9, 0, 5, 7'b1100100, 1, 1'b0);
    run_instr(4'h9, 3, 8, 7'b1100100, 4, 1'b0);
    run_instr(4'h8, 0, 4, 7'b0000101, 1, 1'b0);
    run_instr(4'h8, 2, 6, 7'b0000101, 3, 1'b0);
    run_instr(4'hB, 0, 3, 7'b0010010, 0, 1'b0);
    run_instr(4'hD, 0, 3, 7'b0001011, 0, 1'b0);
    run_instr(4'hC, 0, 3, 7'b0010010, 0, 1'b0);
    run_instr(4'h7, 0, 4, 7'b0100100, 0, 1'b0);
    run_instr(4'h5, 0, 4, 7'b0100000, 0, 1'b0);
    run_instr(4'hE, 0, 2, 7'b0000000, 0, 1'b0);

    // Asynchronous reset in the middle of a stalled store.
    @(posedge clk); #1;
    start_stuck_store();
    repeat (4) @(posedge clk); #1;
    check_eq("memwrite_before_reset", bus.MemWrite, 1'b1);
    #2 reset = 1'b0;
    #1;
    check_eq("async_reset_outputs", outs, 15'd0);
    check_eq("async_reset_retired", bus.retired, 0);
    @(negedge clk) reset = 1'b1;
    exp_retired = 0;

    // Store that never completes runs into the memory timeout.
    @(posedge clk); #1;
    start_stuck_store();
    wait_halted();
    check_eq("timeout_memwrite_cycles", mem_cnt, 15);
    check_eq("timeout_mem_err", bus.mem_err, 1'b1);
    check_eq("timeout_halted", bus.halted, 1'b1);
    check_eq("timeout_retired", bus.retired, 0);
    check_eq("timeout_state", bus.state_dbg, 3'd6);
    check_eq("timeout_strobe_drop", bus.MemWrite, 1'b0);

    reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check_eq("reset_clears_mem_err", bus.mem_err, 1'b0);
    check_eq("reset_clears_halted", bus.halted, 1'b0);

    // NOP with run dropped, then HALT.
    run_instr(4'hE, 0, 2, 7'b0000000, 0, 1'b1);
    check_eq("nop_to_idle", bus.state_dbg, 3'd0);
    repeat (3) @(posedge clk); #1;
    check_eq("idle_holds", bus.state_dbg, 3'd0);
    bus.run = 1'b1;
    bus.opcode = 4'hF;
    bus.instr_valid = 1'b1;
    wait_ir_load();
    @(negedge clk);
    bus.instr_valid = 1'b0;
    wait_halted();
    check_eq("halt_halted", bus.halted, 1'b1);
    check_eq("halt_retired", bus.retired, 2);
    check_eq("halt_state", bus.state_dbg, 3'd6);
    bus.opcode = 4'h0;
    bus.instr_valid = 1'b1;
    repeat (10) @(posedge clk); #1;
    check_eq("halt_ignores_retired", bus.retired, 2);
    check_eq("halt_ignores_state", bus.state_dbg, 3'd6);
    check_eq("halt_ignores_ir_load", bus.ir_load, 1'b0);
    check_eq("sb_empty_at_end", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
